instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage of the 8-bit RISC CPU. Holds the program counter and the instruction register.
- Assembles one- or two-byte instructions from the 8-bit ROM data bus and drives the 3-bit opcode `ins` into the controller FSM.
- Consumes the controller's PC_en, fetch, rom_ena, rom_read and ad_sel strobes.
- Produces the ROM/RAM address bus: PC, or the operand address when ad_sel=1.

Parameters:
- DATA_W, 8, ROM data / instruction byte width.
- ADDR_W, 8, PC and memory address width.
- REG_ADDR_W, 5, register-file address field width (DATA_W-3).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_data  in  DATA_W  ROM read data, valid in the capture cycle.
- PC_en  in  1  increment PC this cycle.
- fetch  in  2  controller fetch code; 2'b01 = fetch from ROM/RAM.
- rom_ena  in  1  ROM enable.
- rom_read  in  1  ROM read strobe.
- ad_sel  in  1  0: address bus = PC; 1: address bus = operand address.
- ins  out  3  current opcode (IR byte0[7:5]).
- reg_addr  out  REG_ADDR_W  register address (IR byte0[4:0]).
- mem_addr  out  ADDR_W  operand address (IR byte1).
- pc  out  ADDR_W  program counter.
- addr_bus  out  ADDR_W  ad_sel ? mem_addr : pc (combinational).
- ir_valid  out  1  full instruction held (short, or long with byte1 captured).
- halted  out  1  HLT captured; sticky until rst.
- pc_wrap  out  1  one-cycle pulse when PC rolls from all-ones to 0.

Behaviour:
- Decided interface fact: one clock; reset is synchronous and active-high.
- Reset values, applied at the edge where rst=1: pc=RESET_PC, byte0=0 (ins=NOP), byte1=0, phase=0, ir_valid=0, halted=0, pc_wrap=0. rst has priority over every other input.
- capture = (fetch==2'b01) & rom_ena & rom_read & ~halted. fetch=01 without rom_read (STO/PRE/ADD read cycles) does not capture. rom_read with fetch=00 (LDO data read) does not capture.
- Opcodes: NOP=000, LDO=001, LDA=010, STO=011, PRE=100, ADD=101, LDM=110, HLT=111.
- Long instructions: LDO, LDA, STO (two bytes). All other opcodes are short (one byte).
- Phase FSM, 2 states:
  - P_OP (phase=0), on capture:
    - byte0<=rom_data.
    - Long opcode: phase<=P_ARG, ir_valid<=0.
    - Short opcode: byte1<=0, ir_valid<=1, stay P_OP.
    - Opcode HLT: also halted<=1.
  - P_ARG (phase=1), on capture: byte1<=rom_data, ir_valid<=1, phase<=P_OP.
  - No capture: hold state.
- PC: if PC_en & ~halted then pc<=pc+1 modulo 2^ADDR_W.
  - Increment from all-ones gives pc=0 and pc_wrap=1 for exactly that following cycle.
  - pc_wrap is 0 at all other times.
- Simultaneous capture and PC_en: both take effect. The captured byte is the one addressed by the pre-increment PC.
- While halted: PC_en and capture are ignored. Outputs hold. Only rst clears halted.
- Outputs ins, reg_addr and mem_addr are registered: a value captured at edge N is visible from cycle N+1. This satisfies the controller sampling ins in S1.
- addr_bus is combinational, with zero-cycle latency from ad_sel.
- Reset mid-instruction, e.g. between byte0 and byte1 of STO: phase returns to P_OP, and the next capture is treated as byte0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams NOP..HLT;
  - fetch codes FETCH_NONE=2'b00, FETCH_MEM=2'b01, FETCH_REG=2'b10;
  - function is_long(op);
  - controller state codes, so the controller and this block use one definition.
- Sub-module pc_counter (ADDR_W, RESET_PC): en, hold, wrap pulse.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> pc=00, ins=000, reg_addr=0, mem_addr=00, ir_valid=0, halted=0, addr_bus=00.
- LDA: rom[00]=8'h43, rom[01]=8'h2A; drive the S0,S1,S3,S4 strobe sequence -> after S0 ins=010, reg_addr=3, ir_valid=0; after S3 mem_addr=2A, ir_valid=1; pc=02; ad_sel=1 -> addr_bus=2A.
- Short ADD with false strobes: rom[02]=8'hA5 -> ins=101, reg_addr=5, mem_addr=00, ir_valid=1, phase stays P_OP. Then fetch=01/rom_read=0, and fetch=00/rom_read=1 -> IR unchanged.
- Wrap: preload pc=FF via strobes, pulse PC_en -> pc=00, pc_wrap=1 for one cycle, then 0.
- HLT: capture 8'hE0, then 3 PC_en pulses and a capture of 8'h43 -> halted=1, pc frozen, ins=111. Then rst -> halted=0, pc=00.
- Reset mid-STO: capture 8'h61, assert rst, then capture 8'hA0 -> ins=101, ir_valid=1, mem_addr=00, i.e. 8'hA0 is treated as byte0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU.
// Opcodes, fetch codes and controller state codes.
package cpu_pkg;

   localparam logic [2:0] NOP = 3'b000;
   localparam logic [2:0] LDO = 3'b001;
   localparam logic [2:0] LDA = 3'b010;
   localparam logic [2:0] STO = 3'b011;
   localparam logic [2:0] PRE = 3'b100;
   localparam logic [2:0] ADD = 3'b101;
   localparam logic [2:0] LDM = 3'b110;
   localparam logic [2:0] HLT = 3'b111;

   localparam logic [1:0] FETCH_NONE = 2'b00;
   localparam logic [1:0] FETCH_MEM  = 2'b01;
   localparam logic [1:0] FETCH_REG  = 2'b10;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5,
      S6 = 3'd6,
      S7 = 3'd7
   } ctrl_state_t;

   typedef enum logic {
      P_OP  = 1'b0,
      P_ARG = 1'b1
   } phase_t;

   function automatic logic is_long(input logic [2:0] op);
      return (op == LDO) || (op == LDA) || (op == STO);
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter with enable, hold and a one-cycle wrap pulse.
// The pulse is high in the cycle after the all-ones to zero roll.
module pc_counter #(
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              hold,
   output logic [ADDR_W-1:0] pc,
   output logic              wrap
);

   logic [ADDR_W-1:0] pc_d, pc_q;
   logic              wrap_d, wrap_q;
   logic              step;

   always_comb begin
      step   = en & ~hold;
      pc_d   = pc_q;
      wrap_d = 1'b0;
      if (step) begin
         pc_d   = pc_q + 1'b1;
         wrap_d = &pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= ADDR_W'(RESET_PC);
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end

   assign pc   = pc_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC plus a two-byte instruction register
// assembled from the 8-bit ROM bus.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int REG_ADDR_W = 5,
   parameter int RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     rom_data,
   input  logic                  PC_en,
   input  logic [1:0]            fetch,
   input  logic                  rom_ena,
   input  logic                  rom_read,
   input  logic                  ad_sel,
   output logic [2:0]            ins,
   output logic [REG_ADDR_W-1:0] reg_addr,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [ADDR_W-1:0]     pc,
   output logic [ADDR_W-1:0]     addr_bus,
   output logic                  ir_valid,
   output logic                  halted,
   output logic                  pc_wrap
);

   phase_t            phase_d, phase_q;
   logic [DATA_W-1:0] byte0_d, byte0_q;
   logic [DATA_W-1:0] byte1_d, byte1_q;
   logic              ir_valid_d, ir_valid_q;
   logic              halted_d, halted_q;
   logic              capture;
   logic [2:0]        op_in;

   assign op_in   = rom_data[DATA_W-1 -: 3];
   assign capture = (fetch == FETCH_MEM) & rom_ena
                  & rom_read & ~halted_q;

   always_comb begin
      phase_d    = phase_q;
      byte0_d    = byte0_q;
      byte1_d    = byte1_q;
      ir_valid_d = ir_valid_q;
      halted_d   = halted_q;
      if (capture) begin
         unique case (phase_q)
            P_OP: begin
               byte0_d = rom_data;
               if (is_long(op_in)) begin
                  phase_d    = P_ARG;
                  ir_valid_d = 1'b0;
               end else begin
                  byte1_d    = '0;
                  ir_valid_d = 1'b1;
                  halted_d   = (op_in == HLT);
               end
            end
            P_ARG: begin
               byte1_d    = rom_data;
               ir_valid_d = 1'b1;
               phase_d    = P_OP;
            end
            default: phase_d = P_OP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= P_OP;
         byte0_q    <= '0;
         byte1_q    <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         byte0_q    <= byte0_d;
         byte1_q    <= byte1_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk  (clk),
      .rst  (rst),
      .en   (PC_en),
      .hold (halted_q),
      .pc   (pc),
      .wrap (pc_wrap)
   );

   assign ins      = byte0_q[DATA_W-1 -: 3];
   assign reg_addr = byte0_q[REG_ADDR_W-1:0];
   assign mem_addr = ADDR_W'(byte1_q);
   assign ir_valid = ir_valid_q;
   assign halted   = halted_q;
   assign addr_bus = ad_sel ? mem_addr : pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a ROM array
// addressed by the DUT address bus.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rom_data;
   logic       PC_en;
   logic [1:0] fetch;
   logic       rom_ena;
   logic       rom_read;
   logic       ad_sel;
   logic [2:0] ins;
   logic [4:0] reg_addr;
   logic [7:0] mem_addr;
   logic [7:0] pc;
   logic [7:0] addr_bus;
   logic       ir_valid;
   logic       halted;
   logic       pc_wrap;

   logic [7:0] rom [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rom_data = rom[addr_bus];

   instr_fetch dut (
      .clk      (clk),
      .rst      (rst),
      .rom_data (rom_data),
      .PC_en    (PC_en),
      .fetch    (fetch),
      .rom_ena  (rom_ena),
      .rom_read (rom_read),
      .ad_sel   (ad_sel),
      .ins      (ins),
      .reg_addr (reg_addr),
      .mem_addr (mem_addr),
      .pc       (pc),
      .addr_bus (addr_bus),
      .ir_valid (ir_valid),
      .halted   (halted),
      .pc_wrap  (pc_wrap)
   );

   task automatic step(input logic [1:0] f, input logic ena,
                       input logic rd, input logic pe);
      fetch    = f;
      rom_ena  = ena;
      rom_read = rd;
      PC_en    = pe;
      @(posedge clk);
      #1;
      fetch    = 2'b00;
      rom_ena  = 1'b0;
      rom_read = 1'b0;
      PC_en    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         fetch    = 2'($urandom_range(3));
         rom_ena  = 1'($urandom_range(1));
         rom_read = 1'($urandom_range(1));
         PC_en    = 1'($urandom_range(1));
         ad_sel   = 1'($urandom_range(1));
         @(posedge clk);
      end
      #1;
      rst = 1'b0; fetch = 2'b00; rom_ena = 0;
      rom_read = 0; PC_en = 0; ad_sel = 0;
      #1;
      checks++;
      if ({pc, ins, reg_addr, mem_addr} !== 24'h0) begin
         errors++;
         $display("FAIL reset_ir got pc=%h ins=%b ra=%h ma=%h exp zeros",
                  pc, ins, reg_addr, mem_addr);
      end
      checks++;
      if ({ir_valid, halted, pc_wrap, addr_bus} !== 11'h0) begin
         errors++;
         $display("FAIL reset_flags got v=%b h=%b w=%b ab=%h exp 0",
                  ir_valid, halted, pc_wrap, addr_bus);
      end
   endtask

   task automatic test_lda();
      rom[8'h00] = 8'h43;
      rom[8'h01] = 8'h2A;
      step(2'b01, 1, 1, 1);
      checks++;
      if ({ins, reg_addr, ir_valid, pc} !== {3'b010, 5'd3, 1'b0, 8'h01}) begin
         errors++;
         $display("FAIL lda_s0 got ins=%b ra=%h v=%b pc=%h exp 010 03 0 01",
                  ins, reg_addr, ir_valid, pc);
      end
      step(2'b00, 0, 0, 0);
      step(2'b01, 1, 1, 1);
      checks++;
      if ({mem_addr, ir_valid, pc} !== {8'h2A, 1'b1, 8'h02}) begin
         errors++;
         $display("FAIL lda_s3 got ma=%h v=%b pc=%h exp 2a 1 02",
                  mem_addr, ir_valid, pc);
      end
      ad_sel = 1'b1;
      #1;
      checks++;
      if (addr_bus !== 8'h2A) begin
         errors++;
         $display("FAIL lda_addr_bus got %h exp 2a", addr_bus);
      end
      ad_sel = 1'b0;
      #1;
      checks++;
      if (addr_bus !== 8'h02) begin
         errors++;
         $display("FAIL lda_pc_bus got %h exp 02", addr_bus);
      end
   endtask

   task automatic test_short_add();
      rom[8'h02] = 8'hA5;
      rom[8'h03] = 8'h43;
      step(2'b01, 1, 1, 1);
      checks++;
      if ({ins, reg_addr, mem_addr, ir_valid} !== {3'b101, 5'd5, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL add got ins=%b ra=%h ma=%h v=%b exp 101 05 00 1",
                  ins, reg_addr, mem_addr, ir_valid);
      end
      step(2'b01, 1, 0, 0);
      step(2'b00, 1, 1, 0);
      checks++;
      if ({ins, reg_addr, ir_valid, pc} !== {3'b101, 5'd5, 1'b1, 8'h03}) begin
         errors++;
         $display("FAIL false_strobe got ins=%b ra=%h v=%b pc=%h exp 101 05 1 03",
                  ins, reg_addr, ir_valid, pc);
      end
      rom[8'h03] = 8'hC7;
      step(2'b01, 1, 1, 0);
      checks++;
      if ({ins, reg_addr, ir_valid} !== {3'b110, 5'd7, 1'b1}) begin
         errors++;
         $display("FAIL phase_op got ins=%b ra=%h v=%b exp 110 07 1",
                  ins, reg_addr, ir_valid);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 252; i++) step(2'b00, 0, 0, 1);
      checks++;
      if ({pc, pc_wrap} !== {8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL wrap_pre got pc=%h w=%b exp ff 0", pc, pc_wrap);
      end
      step(2'b00, 0, 0, 1);
      checks++;
      if ({pc, pc_wrap} !== {8'h00, 1'b1}) begin
         errors++;
         $display("FAIL wrap_pulse got pc=%h w=%b exp 00 1", pc, pc_wrap);
      end
      step(2'b00, 0, 0, 0);
      checks++;
      if ({pc, pc_wrap} !== {8'h00, 1'b0}) begin
         errors++;
         $display("FAIL wrap_end got pc=%h w=%b exp 00 0", pc, pc_wrap);
      end
   endtask

   task automatic test_halt();
      rom[8'h00] = 8'hE0;
      rom[8'h01] = 8'h43;
      step(2'b01, 1, 1, 1);
      for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 1);
      step(2'b01, 1, 1, 0);
      checks++;
      if ({halted, ins, pc, ir_valid} !== {1'b1, 3'b111, 8'h01, 1'b1}) begin
         errors++;
         $display("FAIL halt got h=%b ins=%b pc=%h v=%b exp 1 111 01 1",
                  halted, ins, pc, ir_valid);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({halted, pc, ins} !== {1'b0, 8'h00, 3'b000}) begin
         errors++;
         $display("FAIL halt_rst got h=%b pc=%h ins=%b exp 0 00 000",
                  halted, pc, ins);
      end
   endtask

   task automatic test_reset_mid_sto();
      rom[8'h00] = 8'h61;
      step(2'b01, 1, 1, 1);
      checks++;
      if ({ins, ir_valid} !== {3'b011, 1'b0}) begin
         errors++;
         $display("FAIL sto_b0 got ins=%b v=%b exp 011 0", ins, ir_valid);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rom[8'h00] = 8'hA0;
      step(2'b01, 1, 1, 1);
      checks++;
      if ({ins, ir_valid, mem_addr, reg_addr} !== {3'b101, 1'b1, 8'h00, 5'd0}) begin
         errors++;
         $display("FAIL mid_sto got ins=%b v=%b ma=%h ra=%h exp 101 1 00 00",
                  ins, ir_valid, mem_addr, reg_addr);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rst = 1'b1; fetch = 2'b00; rom_ena = 0;
      rom_read = 0; PC_en = 0; ad_sel = 0;
      test_reset();
      test_lda();
      test_short_add();
      test_wrap();
      test_halt();
      test_reset_mid_sto();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
